// File: rtl/pong_ball_ctrl.sv
// ---------------------------------------------------------------------------
// pong_ball_ctrl
//   Ball/score controller for the LED-bar ping-pong game. It moves a one-hot
//   ball one LED per divider tick and judges paddle presses at each end of
//   the bar. It keeps both scores, flashes the bar after each point, and
//   latches the winner when either score reaches WIN_SCORE.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-high
//   tick       in   single-cycle ball-step strobe
//   btn_l      in   left paddle pulse (debounced, single cycle)
//   btn_r      in   right paddle pulse (debounced, single cycle)
//   led        out  ball display, led[WIDTH-1] is the leftmost LED
//   score_l    out  left player score
//   score_r    out  right player score
//   game_over  out  high once a player has reached WIN_SCORE
//   winner     out  1 = left won, 0 = right won (valid with game_over)
// ---------------------------------------------------------------------------
module pong_ball_ctrl #(
    parameter int WIDTH      = 8,
    parameter int WIN_SCORE  = 9,
    parameter int HOLD_TICKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_l,
    input  logic             btn_r,
    output logic [WIDTH-1:0] led,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r,
    output logic             game_over,
    output logic             winner
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS - 1);
    localparam logic [3:0]    WIN_VAL  = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_R    = 3'd1,
        MOVE_L    = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_pos, w_pos_next;
    logic [HW-1:0]   r_hold, w_hold_next;
    logic [3:0]      r_score_l, w_score_l_next;
    logic [3:0]      r_score_r, w_score_r_next;
    logic [WIDTH-1:0] r_led, w_led_next;
    logic            r_game_over, r_winner;

    // Game-over display masks: the left winner gets the upper half, which
    // takes the extra LED when WIDTH is odd.
    logic [WIDTH-1:0] w_mask_upper;
    logic [WIDTH-1:0] w_mask_lower;
    logic [WIDTH-1:0] w_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign w_mask_upper[gi] = (gi >= WIDTH / 2);
            assign w_mask_lower[gi] = (gi <  WIDTH / 2);
        end
    endgenerate

    assign w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << r_pos;

    // Next-state, position, score and hold-counter logic.
    always_comb begin
        w_state_next   = r_state;
        w_pos_next     = r_pos;
        w_hold_next    = r_hold;
        w_score_l_next = r_score_l;
        w_score_r_next = r_score_r;
        unique case (r_state)
            IDLE: begin
                if (btn_l) begin
                    w_pos_next   = POS_MAX;
                    w_state_next = MOVE_R;
                end else if (btn_r) begin
                    w_pos_next   = '0;
                    w_state_next = MOVE_L;
                end
            end
            MOVE_R: begin
                // The paddle press is judged before the tick, so a press on
                // the same cycle as the final tick still counts as a hit.
                if (btn_r) begin
                    if (r_pos == '0) begin
                        w_state_next = MOVE_L;
                    end else begin
                        w_score_l_next = r_score_l + 4'd1;
                        w_hold_next    = '0;
                        w_state_next   = POINT;
                    end
                end else if (tick) begin
                    if (r_pos != '0) begin
                        w_pos_next = r_pos - PW'(1);
                    end else begin
                        w_score_l_next = r_score_l + 4'd1;
                        w_hold_next    = '0;
                        w_state_next   = POINT;
                    end
                end
            end
            MOVE_L: begin
                if (btn_l) begin
                    if (r_pos == POS_MAX) begin
                        w_state_next = MOVE_R;
                    end else begin
                        w_score_r_next = r_score_r + 4'd1;
                        w_hold_next    = '0;
                        w_state_next   = POINT;
                    end
                end else if (tick) begin
                    if (r_pos != POS_MAX) begin
                        w_pos_next = r_pos + PW'(1);
                    end else begin
                        w_score_r_next = r_score_r + 4'd1;
                        w_hold_next    = '0;
                        w_state_next   = POINT;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (r_hold == HOLD_END) begin
                        w_hold_next = '0;
                        if ((r_score_l == WIN_VAL) || (r_score_r == WIN_VAL))
                            w_state_next = GAME_OVER;
                        else
                            w_state_next = IDLE;
                    end else begin
                        w_hold_next = r_hold + HW'(1);
                    end
                end
            end
            GAME_OVER: begin
                // Terminal until reset.
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // LED pattern is derived from the registered state/position, so the bar
    // follows the ball one cycle after the position changes.
    always_comb begin
        w_led_next = '0;
        unique case (r_state)
            MOVE_R, MOVE_L: w_led_next = w_onehot;
            POINT:          w_led_next = '1;
            GAME_OVER:      w_led_next = (r_score_l == WIN_VAL) ? w_mask_upper
                                                                : w_mask_lower;
            default:        w_led_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_hold      <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_led       <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pos       <= w_pos_next;
            r_hold      <= w_hold_next;
            r_score_l   <= w_score_l_next;
            r_score_r   <= w_score_r_next;
            r_led       <= w_led_next;
            r_game_over <= (w_state_next == GAME_OVER);
            r_winner    <= (w_state_next == GAME_OVER) && (w_score_l_next == WIN_VAL);
        end
    end

    assign led       = r_led;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_ball_ctrl
//   Directed bench for pong_ball_ctrl with WIDTH=8, WIN_SCORE=3,
//   HOLD_TICKS=2. Each stimulus pulse lasts one cycle and is followed by one
//   quiet cycle so the registered LED output has settled before checking.
// ---------------------------------------------------------------------------
module tb_pong_ball_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       btn_l;
    logic       btn_r;
    logic [7:0] led;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;

    int n_checks;
    int n_errors;

    pong_ball_ctrl #(
        .WIDTH      (8),
        .WIN_SCORE  (3),
        .HOLD_TICKS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .led       (led),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One-cycle pulse, then a quiet cycle; returns at a falling edge.
    task automatic drive(input logic t, input logic l, input logic r);
        @(negedge clk);
        tick  = t;
        btn_l = l;
        btn_r = r;
        @(negedge clk);
        tick  = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] exp_led;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        tick  = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_led",       led,       8'h00);
        check_val("rst_score_l",   score_l,   4'd0);
        check_val("rst_score_r",   score_r,   4'd0);
        check_val("rst_game_over", game_over, 1'b0);
        check_val("rst_winner",    winner,    1'b0);

        // IDLE ignores tick
        drive(1'b1, 1'b0, 1'b0);
        check_val("idle_tick_led", led, 8'h00);

        // Serve from the left, ball walks right
        drive(1'b0, 1'b1, 1'b0);
        check_val("serve_l_led", led, 8'h80);
        exp_led = 8'h80;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_led = exp_led >> 1;
            check_val($sformatf("walk_r_%0d", i), led, exp_led);
        end

        // Right paddle hit at the end
        drive(1'b0, 1'b0, 1'b1);
        check_val("hit_r_led",     led,     8'h01);
        check_val("hit_r_score_l", score_l, 4'd0);
        check_val("hit_r_score_r", score_r, 4'd0);
        exp_led = 8'h01;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_led = exp_led << 1;
            check_val($sformatf("walk_l_%0d", i), led, exp_led);
        end

        // Left paddle hit at the left end, then walk back down to 0x01
        drive(1'b0, 1'b1, 1'b0);
        check_val("hit_l_led", led, 8'h80);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0);
        check_val("back_at_end", led, 8'h01);

        // Miss at the right end: left scores, flash, then IDLE after 2 ticks
        drive(1'b1, 1'b0, 1'b0);
        check_val("miss_r_score_l", score_l, 4'd1);
        check_val("miss_r_led",     led,     8'hFF);
        drive(1'b1, 1'b0, 1'b0);
        check_val("hold1_led", led, 8'hFF);
        drive(1'b1, 1'b0, 1'b0);
        check_val("hold2_idle_led", led, 8'h00);

        // Both buttons in IDLE: left serve wins
        drive(1'b0, 1'b1, 1'b1);
        check_val("both_btn_led", led, 8'h80);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
        check_val("at_0x10", led, 8'h10);
        // Early swing by the right player
        drive(1'b0, 1'b0, 1'b1);
        check_val("early_score_l", score_l, 4'd2);
        check_val("early_led",     led,     8'hFF);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_val("early_idle_led", led, 8'h00);

        // btn_r together with tick at pos 0 counts as a hit
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check_val("tick_hit_score_l", score_l, 4'd2);
        check_val("tick_hit_led",     led,     8'h01);
        drive(1'b1, 1'b0, 1'b0);
        check_val("tick_hit_move", led, 8'h02);
        // Walk to the left end and miss there: right scores
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
        check_val("left_end", led, 8'h80);
        drive(1'b1, 1'b0, 1'b0);
        check_val("miss_l_score_r", score_r, 4'd1);
        check_val("miss_l_score_l", score_l, 4'd2);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_val("miss_l_idle", led, 8'h00);

        // Left takes the third point via an early right swing -> game over
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_val("win_score_l", score_l, 4'd3);
        check_val("win_pending", game_over, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_val("go_flag",   game_over, 1'b1);
        check_val("go_winner", winner,    1'b1);
        check_val("go_led",    led,       8'hF0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        check_val("go_hold_led",     led,       8'hF0);
        check_val("go_hold_score_l", score_l,   4'd3);
        check_val("go_hold_score_r", score_r,   4'd1);
        check_val("go_hold_flag",    game_over, 1'b1);
        check_val("go_hold_winner",  winner,    1'b1);

        // Asynchronous reset mid-rally
        do_reset();
        check_val("rst2_led", led, 8'h00);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_val("rally_led",     led,     8'h20);
        check_val("rally_score_l", score_l, 4'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_led",     led,       8'h00);
        check_val("async_score_l", score_l,   4'd0);
        check_val("async_go",      game_over, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
